// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: instruction width, NOP encoding, reset PC, PC increment.
`timescale 1ns/1ps
package mips_defs;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/instruction_memory.sv
// Synchronous-read instruction ROM. The output register doubles as the IF/ID instruction
// register; bubbles are muxed in after the array so the ROM contents are never gated.
`timescale 1ns/1ps
module instruction_memory
    import mips_defs::*;
#(
    parameter int unsigned B         = INSTR_W,
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = "prog.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] addr,
    output logic [B-1:0]      rdata
);

    logic [B-1:0] mem [2**ADDR_W];
    logic [B-1:0] rdata_q;

    // IF/ID instruction register: NOP on reset or bubble, hold when not loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= B'(NOP);
        end else if (load) begin
            rdata_q <= bubble ? B'(NOP) : mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC mux, PC+4 adder and the
// IF/ID pipeline register (ROM output register plus PC+4 and valid registers).
// Optional macro IF_STALL_EN adds the stall port; without it the stage never stalls.
`timescale 1ns/1ps
module instruction_fetch
    import mips_defs::*;
#(
    parameter int unsigned  B         = INSTR_W,
    parameter int unsigned  ADDR_W    = 10,
    parameter logic [B-1:0] RESET_PC  = B'(RESET_PC_DEFAULT),
    parameter string        INIT_FILE = "prog.hex"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pc_src,
    input  logic [B-1:0] pc_branch,
    input  logic         flush,
`ifdef IF_STALL_EN
    input  logic         stall,
`endif
    output logic [B-1:0] instruction,
    output logic [B-1:0] pc_incrementado,
    output logic         instr_valid,
    output logic [B-1:0] pc_out
);

    localparam logic [B-1:0] WORD_MASK  = ~B'(3);
    localparam logic [B-1:0] PC_RST_VAL = RESET_PC & WORD_MASK;

    logic         stall_int;
    logic         hold;
    logic [B-1:0] pc_q, pc_d;
    logic [B-1:0] pc_plus4;
    logic [B-1:0] pc_inc_q, pc_inc_d;
    logic         valid_q, valid_d;

`ifdef IF_STALL_EN
    assign stall_int = stall;
`else
    assign stall_int = 1'b0;
`endif

    // A redirect always wins over a stall.
    assign hold     = stall_int & ~pc_src;
    assign pc_plus4 = pc_q + B'(PC_INC);

    // Next PC and IF/ID side registers, by priority pc_src > stall > flush > normal.
    always_comb begin
        pc_d     = pc_plus4;
        pc_inc_d = pc_plus4;
        valid_d  = 1'b1;
        if (pc_src) begin
            pc_d     = pc_branch & WORD_MASK;
            pc_inc_d = '0;
            valid_d  = 1'b0;
        end else if (stall_int) begin
            pc_d     = pc_q;
            pc_inc_d = pc_inc_q;
            valid_d  = valid_q;
        end else if (flush) begin
            pc_inc_d = '0;
            valid_d  = 1'b0;
        end
    end

    // PC and IF/ID PC+4 / valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RST_VAL;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
        end
    end

    instruction_memory #(
        .B         (B),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_imem (
        .clk    (clk),
        .reset  (reset),
        .load   (~hold),
        .bubble (pc_src | flush),
        .addr   (pc_q[ADDR_W+1:2]),
        .rdata  (instruction)
    );

    assign pc_incrementado = pc_inc_q;
    assign instr_valid     = valid_q;
    assign pc_out          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a cycle-level behavioural model.
// Stall scenarios are exercised only when IF_STALL_EN is defined.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int unsigned ROM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_incrementado;
    logic        instr_valid;
    logic [31:0] pc_out;

    logic [31:0] rom_img [ROM_DEPTH];

    // Reference model state: what the IF/ID outputs and PC must be after each edge.
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_inc = '0;
    logic        m_valid = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .B         (32),
        .ADDR_W    (10),
        .RESET_PC  (32'h0),
        .INIT_FILE ("")
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_src          (pc_src),
        .pc_branch       (pc_branch),
        .flush           (flush),
`ifdef IF_STALL_EN
        .stall           (stall),
`endif
        .instruction     (instruction),
        .pc_incrementado (pc_incrementado),
        .instr_valid     (instr_valid),
        .pc_out          (pc_out)
    );

    // Apply one cycle of inputs, clock it, and advance the model by the stage rules.
    task automatic drive_edge(input logic rst, input logic src, input logic [31:0] br,
                              input logic fl, input logic st);
`ifndef IF_STALL_EN
        st = 1'b0;
`endif
        reset = rst; pc_src = src; pc_branch = br; flush = fl; stall = st;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_inc = 32'h0; m_valid = 1'b0;
        end else if (src) begin
            m_pc = (br / 4) * 4; m_instr = 32'h0; m_inc = 32'h0; m_valid = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (fl) begin
            m_instr = 32'h0; m_inc = 32'h0; m_valid = 1'b0; m_pc = m_pc + 4;
        end else begin
            m_instr = rom_img[(m_pc / 4) % ROM_DEPTH];
            m_inc = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
        end
        reset = 1'b0; pc_src = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic advance_to(input logic [31:0] target);
        for (int i = 0; i < 64 && m_pc != target; i++) drive_edge(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_edge(1, 0, 0, 0, 0);
        vectors++;
        if (pc_out !== 32'h0 || instruction !== 32'h0 || pc_incrementado !== 32'h0 ||
            instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h ins=%h inc=%h v=%b want all zero",
                     pc_out, instruction, pc_incrementado, instr_valid);
        end
        drive_edge(0, 0, 0, 0, 0);
        vectors++;
        if (instruction !== rom_img[0] || pc_incrementado !== 32'h4 || instr_valid !== 1'b1)
        begin
            errors++;
            $display("FAIL first_fetch: got ins=%h inc=%h v=%b want ins=%h inc=4 v=1",
                     instruction, pc_incrementado, instr_valid, rom_img[0]);
        end
    endtask

    task automatic test_sequential();
        for (int k = 1; k < 3; k++) begin
            drive_edge(0, 0, 0, 0, 0);
            vectors++;
            if (instruction !== rom_img[k] || pc_incrementado !== 32'(4 * (k + 1)) ||
                instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL sequential_%0d: got ins=%h inc=%h v=%b want ins=%h inc=%h v=1",
                         k, instruction, pc_incrementado, instr_valid, rom_img[k], 4 * (k + 1));
            end
        end
    endtask

    task automatic test_branch();
        drive_edge(1, 0, 0, 0, 0);
        advance_to(32'h10);
        drive_edge(0, 1, 32'h40, 0, 0);
        vectors++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h40) begin
            errors++;
            $display("FAIL branch_bubble: got v=%b ins=%h pc=%h want v=0 ins=0 pc=40",
                     instr_valid, instruction, pc_out);
        end
        drive_edge(0, 0, 0, 0, 0);
        vectors++;
        if (instruction !== rom_img[16] || pc_incrementado !== 32'h44) begin
            errors++;
            $display("FAIL branch_target: got ins=%h inc=%h want ins=%h inc=44",
                     instruction, pc_incrementado, rom_img[16]);
        end
    endtask

    task automatic test_flush_wrap();
        drive_edge(1, 0, 0, 0, 0);
        advance_to(32'h8);
        drive_edge(0, 0, 0, 1, 0);
        vectors++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc_incrementado !== 32'h0 ||
            pc_out !== 32'hC) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b ins=%h inc=%h pc=%h want v=0 ins=0 inc=0 pc=c",
                     instr_valid, instruction, pc_incrementado, pc_out);
        end
        drive_edge(0, 0, 0, 0, 0);
        vectors++;
        if (instruction !== rom_img[3] || pc_incrementado !== 32'h10 || instr_valid !== 1'b1)
        begin
            errors++;
            $display("FAIL flush_resume: got ins=%h inc=%h v=%b want ins=%h inc=10 v=1",
                     instruction, pc_incrementado, instr_valid, rom_img[3]);
        end
        // flush together with pc_src behaves as pc_src alone; target is also misaligned
        drive_edge(0, 1, 32'hFFFF_FFFE, 1, 0);
        vectors++;
        if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_target: got pc=%h v=%b want pc=fffffffc v=0",
                     pc_out, instr_valid);
        end
        drive_edge(0, 0, 0, 0, 0);
        vectors++;
        if (pc_incrementado !== 32'h0 || pc_out !== 32'h0 || instruction !== rom_img[1023] ||
            instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_increment: got inc=%h pc=%h ins=%h v=%b want inc=0 pc=0 ins=%h v=1",
                     pc_incrementado, pc_out, instruction, instr_valid, rom_img[1023]);
        end
    endtask

`ifdef IF_STALL_EN
    task automatic test_stall();
        drive_edge(1, 0, 0, 0, 0);
        advance_to(32'h8);
        for (int i = 0; i < 2; i++) begin
            drive_edge(0, 0, 0, i == 1, 1);
            vectors++;
            if (pc_out !== 32'h8 || instruction !== rom_img[1] || pc_incrementado !== 32'h8 ||
                instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%h ins=%h inc=%h v=%b want pc=8 ins=%h inc=8 v=1",
                         i, pc_out, instruction, pc_incrementado, instr_valid, rom_img[1]);
            end
        end
        drive_edge(0, 0, 0, 0, 0);
        vectors++;
        if (instruction !== rom_img[2] || pc_incrementado !== 32'hC) begin
            errors++;
            $display("FAIL stall_resume: got ins=%h inc=%h want ins=%h inc=c",
                     instruction, pc_incrementado, rom_img[2]);
        end
        drive_edge(0, 1, 32'h20, 0, 1);
        vectors++;
        if (pc_out !== 32'h20 || instr_valid !== 1'b0 || instruction !== 32'h0) begin
            errors++;
            $display("FAIL stall_redirect: got pc=%h v=%b ins=%h want pc=20 v=0 ins=0",
                     pc_out, instr_valid, instruction);
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        drive_edge(1, 0, 0, 0, 0);
        advance_to(32'h24);
        drive_edge(1, 1, 32'h80, 0, 0);
        vectors++;
        if (pc_out !== 32'h0 || instruction !== 32'h0 || pc_incrementado !== 32'h0 ||
            instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got pc=%h ins=%h inc=%h v=%b want all zero",
                     pc_out, instruction, pc_incrementado, instr_valid);
        end
    endtask

    task automatic test_random();
        drive_edge(1, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            drive_edge($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            vectors++;
            if (pc_out !== m_pc || instruction !== m_instr || pc_incrementado !== m_inc ||
                instr_valid !== m_valid) begin
                errors++;
                $display("FAIL random_%0d: got pc=%h ins=%h inc=%h v=%b want pc=%h ins=%h inc=%h v=%b",
                         n, pc_out, instruction, pc_incrementado, instr_valid,
                         m_pc, m_instr, m_inc, m_valid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom_img[i] = $urandom;
        rom_img[0] = 32'h2008_0005;
        rom_img[1] = 32'h2009_0003;
        rom_img[2] = 32'h0109_5020;
        for (int i = 0; i < ROM_DEPTH; i++) dut.u_imem.mem[i] = rom_img[i];

        test_reset();
        test_sequential();
        test_branch();
        test_flush_wrap();
`ifdef IF_STALL_EN
        test_stall();
`endif
        test_reset_mid_run();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
